// File: rtl/axis_pkt_engine_pkg.sv
// rtl/axis_pkt_engine_pkg.sv - shared types and beat-formatting helpers for the packet engine
package axis_pkt_engine_pkg;

    localparam int KEEP_MAX = 128;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_PORT  = 2'd2
    } pkt_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } engine_state_t;

    // Final-beat keep: low (len mod data_bytes) lanes, or every lane when the remainder is zero.
    function automatic logic [KEEP_MAX-1:0] keep_for_len(input logic [31:0] len, input int data_bytes);
        logic [31:0] r;
        keep_for_len = '0;
        r = len % 32'(data_bytes);
        for (int i = 0; i < KEEP_MAX; i++) begin
            if ((r == 32'd0) ? (i < data_bytes) : (32'(i) < r)) begin
                keep_for_len[i] = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] pattern_byte(input pkt_mode_t mode, input logic [7:0] seed,
                                                input logic [7:0] p, input logic [7:0] k,
                                                input int port);
        case (mode)
            MODE_INCR: pattern_byte = seed + p + k;
            MODE_PORT: pattern_byte = {4'(port), k[3:0]};
            default:   pattern_byte = seed;
        endcase
    endfunction

endpackage

// File: rtl/axis_int.sv
// rtl/axis_int.sv - AXI-Stream bundle carried between packet sources and sinks
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);
    logic                    clk;
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;
    logic [USER_WIDTH-1:0]   tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport Master (input clk, input tready,
                    output tdata, output tkeep, output tstrb, output tlast,
                    output tvalid, output tuser, output tid, output tdest);

    modport Slave (input clk, output tready,
                   input tdata, input tkeep, input tstrb, input tlast,
                   input tvalid, input tuser, input tid, input tdest);
endinterface

// File: rtl/axis_pkt_engine_chan.sv
// rtl/axis_pkt_engine_chan.sv - single-port burst engine: FSM, counters and beat formatting
module axis_pkt_engine_chan
    import axis_pkt_engine_pkg::*;
#(
    parameter int PORT        = 0,
    parameter int DATA_BYTES  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 32,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    sresetn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic [COUNT_WIDTH-1:0]  cfg_count,
    input  logic [GAP_WIDTH-1:0]    cfg_gap,
    input  pkt_mode_t               cfg_mode,
    input  logic [7:0]              cfg_seed,
    input  logic [USER_WIDTH-1:0]   cfg_user,
    output logic [8*DATA_BYTES-1:0] tdata,
    output logic [DATA_BYTES-1:0]   tkeep,
    output logic [DATA_BYTES-1:0]   tstrb,
    output logic                    tlast,
    output logic                    tvalid,
    input  logic                    tready,
    output logic [USER_WIDTH-1:0]   tuser,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
    ,
    output logic [31:0]             stat_pkts,
    output logic [47:0]             stat_bytes
`endif
);

    engine_state_t          state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, off_q, rem;
    logic [COUNT_WIDTH-1:0] count_q, pkt_q, pkt_next;
    logic [GAP_WIDTH-1:0]   gap_q, gap_cnt_q;
    pkt_mode_t              mode_q;
    logic [7:0]             seed_q;
    logic [USER_WIDTH-1:0]  user_q;
    logic                   stop_pend_q, err_q;
    logic                   accept, hs, last_beat, pkt_end, burst_end, gap_last;
    logic [DATA_BYTES-1:0]  keep_last;

    assign accept    = (state_q == IDLE) && start && (cfg_len != '0);
    assign tvalid    = (state_q == SEND);
    assign hs        = tvalid && tready;
    // Beat formatting works from the bytes still owed in this packet.
    assign rem       = len_q - off_q;
    assign last_beat = (rem <= LEN_WIDTH'(DATA_BYTES));
    assign pkt_end   = hs && last_beat;
    assign pkt_next  = pkt_q + 1'b1;
    assign burst_end = ((count_q != '0) && (pkt_next == count_q)) || stop_pend_q || stop;
    assign gap_last  = (gap_cnt_q == gap_q - 1'b1);
    assign keep_last = DATA_BYTES'(keep_for_len(32'(rem), DATA_BYTES));

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SEND;
            end
            SEND: begin
                if (pkt_end) begin
                    if (burst_end) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    if (stop_pend_q || stop) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE) && !done;
    assign cfg_err = err_q;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            off_q       <= '0;
            count_q     <= '0;
            pkt_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            mode_q      <= MODE_CONST;
            seed_q      <= '0;
            user_q      <= '0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && start && (cfg_len == '0);
            if (accept) begin
                len_q       <= cfg_len;
                count_q     <= cfg_count;
                gap_q       <= cfg_gap;
                mode_q      <= cfg_mode;
                seed_q      <= cfg_seed;
                user_q      <= cfg_user;
                off_q       <= '0;
                pkt_q       <= '0;
                gap_cnt_q   <= '0;
                stop_pend_q <= 1'b0;
            end else begin
                if ((state_q != IDLE) && stop) stop_pend_q <= 1'b1;
                if (state_q == GAP) gap_cnt_q <= gap_cnt_q + 1'b1;
                if (pkt_end) begin
                    off_q     <= '0;
                    pkt_q     <= pkt_next;
                    gap_cnt_q <= '0;
                end else if (hs) begin
                    off_q <= off_q + LEN_WIDTH'(DATA_BYTES);
                end
            end
        end
    end

    always_comb begin
        tdata = '0;
        tkeep = '0;
        tlast = 1'b0;
        tuser = '0;
        if (state_q == SEND) begin
            for (int j = 0; j < DATA_BYTES; j++) begin
                if (LEN_WIDTH'(j) < rem) begin
                    tdata[8*j +: 8] = pattern_byte(mode_q, seed_q, 8'(pkt_q),
                                                   8'(off_q + LEN_WIDTH'(j)), PORT);
                end
            end
            tkeep = last_beat ? keep_last : '1;
            tlast = last_beat;
            tuser = user_q;
        end
    end

    assign tstrb = tkeep;

`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
    logic [48:0] bytes_sum;
    assign bytes_sum = {1'b0, stat_bytes} + 49'(len_q);

    always_ff @(posedge clk) begin
        if (!sresetn || accept) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else if (pkt_end) begin
            if (stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
            stat_bytes <= bytes_sum[48] ? '1 : bytes_sum[47:0];
        end
    end
`endif

endmodule

// File: rtl/axis_array_pkt_engine.sv
// rtl/axis_array_pkt_engine.sv - NUM_PORTS independent AXIS burst generators; AXIS_ARRAY_PKT_ENGINE_STATS_EN adds per-port counters
module axis_array_pkt_engine
    import axis_pkt_engine_pkg::*;
#(
    parameter int NUM_PORTS   = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 32,
    parameter int GAP_WIDTH   = 16,
    parameter int DATA_BYTES  = 8,
    parameter int USER_WIDTH  = 1
) (
    input  logic                                  clk,
    input  logic                                  sresetn,
    AXIS_int.Master                               axis_out [NUM_PORTS-1:0],
    input  logic [NUM_PORTS-1:0]                  start,
    input  logic [NUM_PORTS-1:0]                  stop,
    input  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0]   cfg_len,
    input  logic [NUM_PORTS-1:0][COUNT_WIDTH-1:0] cfg_count,
    input  logic [NUM_PORTS-1:0][GAP_WIDTH-1:0]   cfg_gap,
    input  pkt_mode_t [NUM_PORTS-1:0]             cfg_mode,
    input  logic [NUM_PORTS-1:0][7:0]             cfg_seed,
    input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0]  cfg_user,
    output logic [NUM_PORTS-1:0]                  busy,
    output logic [NUM_PORTS-1:0]                  done,
    output logic [NUM_PORTS-1:0]                  cfg_err
`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][31:0]            stat_pkts,
    output logic [NUM_PORTS-1:0][47:0]            stat_bytes
`endif
);

    if (NUM_PORTS < 1) begin : g_bad_num_ports
        $error("axis_array_pkt_engine: NUM_PORTS must be greater than 0");
    end

    // DATA_BYTES/USER_WIDTH must match the parameters of the connected AXIS_int instances.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        axis_pkt_engine_chan #(
            .PORT        (i),
            .DATA_BYTES  (DATA_BYTES),
            .USER_WIDTH  (USER_WIDTH),
            .LEN_WIDTH   (LEN_WIDTH),
            .COUNT_WIDTH (COUNT_WIDTH),
            .GAP_WIDTH   (GAP_WIDTH)
        ) u_chan (
            .clk        (clk),
            .sresetn    (sresetn),
            .start      (start[i]),
            .stop       (stop[i]),
            .cfg_len    (cfg_len[i]),
            .cfg_count  (cfg_count[i]),
            .cfg_gap    (cfg_gap[i]),
            .cfg_mode   (cfg_mode[i]),
            .cfg_seed   (cfg_seed[i]),
            .cfg_user   (cfg_user[i]),
            .tdata      (axis_out[i].tdata),
            .tkeep      (axis_out[i].tkeep),
            .tstrb      (axis_out[i].tstrb),
            .tlast      (axis_out[i].tlast),
            .tvalid     (axis_out[i].tvalid),
            .tready     (axis_out[i].tready),
            .tuser      (axis_out[i].tuser),
            .busy       (busy[i]),
            .done       (done[i]),
            .cfg_err    (cfg_err[i])
`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
            ,
            .stat_pkts  (stat_pkts[i]),
            .stat_bytes (stat_bytes[i])
`endif
        );

        assign axis_out[i].tid   = '0;
        assign axis_out[i].tdest = '0;
    end

endmodule

// File: tb/tb_axis_array_pkt_engine.sv
// tb/tb_axis_array_pkt_engine.sv - directed self-checking bench for axis_array_pkt_engine
module tb_axis_array_pkt_engine;
    import axis_pkt_engine_pkg::*;

    localparam int NP = 2;
    localparam int DB = 8;
    localparam int UW = 4;

    logic clk = 1'b0;
    logic sresetn;
    always #5 clk = ~clk;

    logic [NP-1:0]        start, stop, busy, done, cfg_err, rdy;
    logic [NP-1:0][15:0]  cfg_len;
    logic [NP-1:0][31:0]  cfg_count;
    logic [NP-1:0][15:0]  cfg_gap;
    pkt_mode_t [NP-1:0]   cfg_mode;
    logic [NP-1:0][7:0]   cfg_seed;
    logic [NP-1:0][UW-1:0] cfg_user;
`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
    logic [NP-1:0][31:0]  stat_pkts;
    logic [NP-1:0][47:0]  stat_bytes;
`endif

    AXIS_int #(.DATA_BYTES(DB), .USER_WIDTH(UW)) axis_if [NP-1:0] ();

    assign axis_if[0].clk    = clk;
    assign axis_if[1].clk    = clk;
    assign axis_if[0].tready = rdy[0];
    assign axis_if[1].tready = rdy[1];

    logic          v0, v1, l0, l1;
    logic [63:0]   d0, d1;
    logic [7:0]    k0, k1;
    logic [UW-1:0] u0, u1;
    assign v0 = axis_if[0].tvalid;
    assign v1 = axis_if[1].tvalid;
    assign l0 = axis_if[0].tlast;
    assign l1 = axis_if[1].tlast;
    assign d0 = axis_if[0].tdata;
    assign d1 = axis_if[1].tdata;
    assign k0 = axis_if[0].tkeep;
    assign k1 = axis_if[1].tkeep;
    assign u0 = axis_if[0].tuser;
    assign u1 = axis_if[1].tuser;

    axis_array_pkt_engine #(
        .NUM_PORTS(NP), .LEN_WIDTH(16), .COUNT_WIDTH(32), .GAP_WIDTH(16),
        .DATA_BYTES(DB), .USER_WIDTH(UW)
    ) dut (
        .clk        (clk),
        .sresetn    (sresetn),
        .axis_out   (axis_if),
        .start      (start),
        .stop       (stop),
        .cfg_len    (cfg_len),
        .cfg_count  (cfg_count),
        .cfg_gap    (cfg_gap),
        .cfg_mode   (cfg_mode),
        .cfg_seed   (cfg_seed),
        .cfg_user   (cfg_user),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
        ,
        .stat_pkts  (stat_pkts),
        .stat_bytes (stat_bytes)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_port(input int p, input int len, input int cnt, input int gap,
                            input pkt_mode_t mode, input logic [7:0] seed, input logic [UW-1:0] user);
        cfg_len[p]   = 16'(len);
        cfg_count[p] = 32'(cnt);
        cfg_gap[p]   = 16'(gap);
        cfg_mode[p]  = mode;
        cfg_seed[p]  = seed;
        cfg_user[p]  = user;
    endtask

    function automatic logic [63:0] exp_beat(input pkt_mode_t mode, input logic [7:0] seed,
                                             input int p, input int beat, input int len, input int port);
        logic [63:0] r;
        int k;
        r = '0;
        for (int j = 0; j < DB; j++) begin
            k = beat * DB + j;
            if (k < len) begin
                case (mode)
                    MODE_INCR: r[8*j +: 8] = 8'(int'(seed) + p + k);
                    MODE_PORT: r[8*j +: 8] = 8'((port % 16) * 16 + (k % 16));
                    default:   r[8*j +: 8] = seed;
                endcase
            end
        end
        return r;
    endfunction

    int          beats, idle_run, done_cnt, lasts, done_beat, cyc;
    logic        in_gap, held;
    logic [63:0] hd;
    logic [7:0]  hk;

    initial begin
        sresetn = 1'b0;
        start = '0; stop = '0; rdy = '1;
        cfg_len = '0; cfg_count = '0; cfg_gap = '0; cfg_seed = '0; cfg_user = '0;
        cfg_mode[0] = MODE_CONST; cfg_mode[1] = MODE_CONST;
        repeat (3) tick();

        // reset state
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(cfg_err), 0);
        check("rst_valid", 64'({v1, v0}), 0);
        check("rst_last", 64'({l1, l0}), 0);
        check("rst_data0", d0, 0);
        check("rst_keep0", 64'(k0), 0);
        check("rst_user0", 64'(u0), 0);
        sresetn = 1'b1;
        tick();

        // len 20, count 3, back-to-back, incrementing pattern
        cfg_port(0, 20, 3, 0, MODE_INCR, 8'h10, 4'h5);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int b = 0; b < 9; b++) begin
            check("t1_valid", 64'(v0), 1);
            check("t1_last", 64'(l0), 64'(b % 3 == 2));
            check("t1_keep", 64'(k0), (b % 3 == 2) ? 64'h0F : 64'hFF);
            check("t1_data", d0, exp_beat(MODE_INCR, 8'h10, b / 3, b % 3, 20, 0));
            check("t1_user", 64'(u0), 64'h5);
            check("t1_done", 64'(done[0]), 64'(b == 8));
            check("t1_busy", 64'(busy[0]), 64'(b != 8));
            if (b == 2) check("t1_p0_tail", d0, 64'h0000_0000_2322_2120);
            if (b == 3) check("t1_p1_head", d0, 64'h1817_1615_1413_1211);
            tick();
        end
        check("t1_end_valid", 64'(v0), 0);
        check("t1_end_busy", 64'(busy[0]), 0);
        check("t1_end_done", 64'(done[0]), 0);

        // len 16, count 2, gap 5, random backpressure, port pattern
        cfg_port(0, 16, 2, 5, MODE_PORT, 8'h00, 4'h0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        beats = 0; in_gap = 1'b0; idle_run = 0; held = 1'b0; cyc = 0;
        while (beats < 4 && cyc < 300) begin
            rdy[0] = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                check("t2_hold_valid", 64'(v0), 1);
                check("t2_hold_data", d0, hd);
                check("t2_hold_keep", 64'(k0), 64'(hk));
                held = 1'b0;
            end
            if (!v0 && in_gap) idle_run++;
            if (v0) begin
                if (in_gap) begin
                    check("t2_gap_len", 64'(idle_run), 5);
                    in_gap = 1'b0;
                end
                if (rdy[0]) begin
                    check("t2_data", d0, (beats % 2 == 1) ? 64'h0F0E_0D0C_0B0A_0908 : 64'h0706_0504_0302_0100);
                    check("t2_keep", 64'(k0), 64'hFF);
                    check("t2_last", 64'(l0), 64'(beats % 2));
                    check("t2_done", 64'(done[0]), 64'(beats == 3));
                    if (beats == 1) in_gap = 1'b1;
                    beats++;
                end else begin
                    held = 1'b1; hd = d0; hk = k0;
                end
            end
            cyc++;
            tick();
        end
        rdy[0] = 1'b1;
        check("t2_beats", 64'(beats), 4);
        check("t2_gap_total", 64'(idle_run), 5);
        check("t2_end_busy", 64'(busy[0]), 0);

        // continuous mode, stop during the second beat of packet 4
        cfg_port(0, 24, 0, 0, MODE_INCR, 8'hF0, 4'h0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        beats = 0; lasts = 0; done_cnt = 0; done_beat = -1;
        for (int c = 0; c < 20; c++) begin
            stop[0] = (beats == 10);
            #1;
            if (v0) begin
                if (beats == 9) check("t3_p3_head", 64'(d0[7:0]), 64'hF3);
                if (beats == 10) check("t3_wrap", d0, 64'h0201_00FF_FEFD_FCFB);
                if (l0) lasts++;
                if (done[0]) begin
                    done_cnt++;
                    done_beat = beats;
                end
                beats++;
            end else if (done[0]) begin
                done_cnt++;
            end
            tick();
        end
        stop[0] = 1'b0;
        check("t3_beats", 64'(beats), 12);
        check("t3_lasts", 64'(lasts), 4);
        check("t3_done_cnt", 64'(done_cnt), 1);
        check("t3_done_beat", 64'(done_beat), 11);
        check("t3_busy", 64'(busy[0]), 0);

        // zero-length start is rejected
        cfg_port(0, 0, 1, 0, MODE_CONST, 8'h11, 4'h0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        check("t4_err", 64'(cfg_err[0]), 1);
        check("t4_err_busy", 64'(busy[0]), 0);
        check("t4_err_valid", 64'(v0), 0);
        tick();
        check("t4_err_clear", 64'(cfg_err[0]), 0);

        // start+stop together in IDLE: start wins; later start while busy ignored
        cfg_port(0, 8, 2, 3, MODE_CONST, 8'h77, 4'h0);
        start[0] = 1'b1; stop[0] = 1'b1; tick(); start[0] = 1'b0; stop[0] = 1'b0;
        check("t4_valid", 64'(v0), 1);
        check("t4_data", d0, 64'h7777_7777_7777_7777);
        check("t4_last", 64'(l0), 1);
        cfg_port(0, 0, 1, 0, MODE_CONST, 8'h33, 4'h0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        check("t4_busy_no_err", 64'(cfg_err[0]), 0);
        check("t4_busy_held", 64'(busy[0]), 1);
        check("t4_gap_valid", 64'(v0), 0);
        beats = 1; done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (v0) begin
                check("t4_data2", d0, 64'h7777_7777_7777_7777);
                beats++;
            end
            if (done[0]) done_cnt++;
            tick();
        end
        check("t4_beats", 64'(beats), 2);
        check("t4_done_cnt", 64'(done_cnt), 1);

        // two ports together, then reset mid-burst
        cfg_port(0, 40, 0, 0, MODE_INCR, 8'h00, 4'hA);
        cfg_port(1, 12, 2, 1, MODE_PORT, 8'h00, 4'h9);
        start = 2'b11; tick(); start = 2'b00;
        check("t5_valid0", 64'(v0), 1);
        check("t5_valid1", 64'(v1), 1);
        check("t5_data0", d0, 64'h0706_0504_0302_0100);
        check("t5_data1", d1, 64'h1716_1514_1312_1110);
        check("t5_user0", 64'(u0), 64'hA);
        check("t5_user1", 64'(u1), 64'h9);
        tick();
        check("t5_data0_b1", d0, 64'h0F0E_0D0C_0B0A_0908);
        check("t5_data1_b1", d1, 64'h0000_0000_1B1A_1918);
        check("t5_keep1_b1", 64'(k1), 64'h0F);
        check("t5_last1_b1", 64'(l1), 1);
        tick();
        check("t5_gap1", 64'(v1), 0);
        check("t5_run0", 64'(v0), 1);
        sresetn = 1'b0;
        tick();
        check("t5_rst_valid", 64'({v1, v0}), 0);
        check("t5_rst_busy", 64'(busy), 0);
        check("t5_rst_data0", d0, 0);
        sresetn = 1'b1;
        tick();
        check("t5_idle_busy", 64'(busy), 0);
        check("t5_idle_valid", 64'({v1, v0}), 0);
        cfg_port(0, 8, 1, 0, MODE_CONST, 8'h3C, 4'h0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        check("t5_re_valid", 64'(v0), 1);
        check("t5_re_data", d0, 64'h3C3C_3C3C_3C3C_3C3C);
        check("t5_re_last", 64'(l0), 1);
        check("t5_re_done", 64'(done[0]), 1);
        tick();
        check("t5_re_busy", 64'(busy[0]), 0);

`ifdef AXIS_ARRAY_PKT_ENGINE_STATS_EN
        cfg_port(1, 100, 7, 0, MODE_CONST, 8'h01, 4'h0);
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        cyc = 0;
        while (busy[1] && cyc < 300) begin
            tick();
            cyc++;
        end
        check("st_timeout", 64'(busy[1]), 0);
        tick();
        check("st_pkts", 64'(stat_pkts[1]), 7);
        check("st_bytes", 64'(stat_bytes[1]), 700);
        cfg_port(1, 8, 1, 0, MODE_CONST, 8'h01, 4'h0);
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        check("st_pkts_clr", 64'(stat_pkts[1]), 0);
        check("st_bytes_clr", 64'(stat_bytes[1]), 0);
        repeat (3) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
